hv_encoder_seq: RTL

Micro-program sequencer that drives the control ports of the hypervector encoder (ALU/bundler/register/query-HV muxes and enables). It holds a small instruction memory loaded by the host, replays a program of `prog_len` words `num_iter` times, waits on item-memory input, and applies query-HV back-pressure. It sits between the CSR/host side and the encoder, replacing direct host driving of encoder controls.

---
 rtl/hv_enc_ctrl_pkg.sv | 41 ++++
 rtl/hv_inst_mem.sv | 27 ++
 rtl/hv_encoder_seq.sv | 128 ++++++++++++
 3 files changed

// File: rtl/hv_enc_ctrl_pkg.sv
// Encoder control-word field layout and sequencer state type for the HV encoder sequencer.
package hv_enc_ctrl_pkg;

    localparam int unsigned CtrlBits = 35;

    // Field positions are LSB-first, in encoder port order.
    localparam int unsigned AluMuxALsb     = 0;   localparam int unsigned AluMuxAW     = 2;
    localparam int unsigned AluMuxBLsb     = 2;   localparam int unsigned AluMuxBW     = 2;
    localparam int unsigned AluOpsLsb      = 4;   localparam int unsigned AluOpsW      = 2;
    localparam int unsigned AluShiftAmtLsb = 6;   localparam int unsigned AluShiftAmtW = 7;
    localparam int unsigned BundMuxALsb    = 13;  localparam int unsigned BundMuxAW    = 2;
    localparam int unsigned BundMuxBLsb    = 15;  localparam int unsigned BundMuxBW    = 2;
    localparam int unsigned BundValidALsb  = 17;  localparam int unsigned BundValidAW  = 1;
    localparam int unsigned BundValidBLsb  = 18;  localparam int unsigned BundValidBW  = 1;
    localparam int unsigned BundClrALsb    = 19;  localparam int unsigned BundClrAW    = 1;
    localparam int unsigned BundClrBLsb    = 20;  localparam int unsigned BundClrBW    = 1;
    localparam int unsigned RegMuxLsb      = 21;  localparam int unsigned RegMuxW      = 2;
    localparam int unsigned RegRdAddrALsb  = 23;  localparam int unsigned RegRdAddrAW  = 2;
    localparam int unsigned RegRdAddrBLsb  = 25;  localparam int unsigned RegRdAddrBW  = 2;
    localparam int unsigned RegWrAddrLsb   = 27;  localparam int unsigned RegWrAddrW   = 2;
    localparam int unsigned RegWrEnLsb     = 29;  localparam int unsigned RegWrEnW     = 1;
    localparam int unsigned QhvWenLsb      = 30;  localparam int unsigned QhvWenW      = 1;
    localparam int unsigned QhvClrLsb      = 31;  localparam int unsigned QhvClrW      = 1;
    localparam int unsigned QhvMuxLsb      = 32;  localparam int unsigned QhvMuxW      = 2;
    localparam int unsigned QhvAmLoadLsb   = 34;  localparam int unsigned QhvAmLoadW   = 1;

    localparam logic [CtrlBits-1:0] CtrlOne = 1;

    // Enables that must be suppressed while an instruction is stalled.
    localparam logic [CtrlBits-1:0] EnableMask =
        (CtrlOne << BundValidALsb) | (CtrlOne << BundValidBLsb) |
        (CtrlOne << BundClrALsb)   | (CtrlOne << BundClrBLsb)   |
        (CtrlOne << RegWrEnLsb)    | (CtrlOne << QhvWenLsb)     |
        (CtrlOne << QhvClrLsb)     | (CtrlOne << QhvAmLoadLsb);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_e;

endpackage

// File: rtl/hv_inst_mem.sv
// Instruction store: one synchronous write port, one asynchronous read port, no data reset.
module hv_inst_mem
    import hv_enc_ctrl_pkg::*;
#(
    parameter int unsigned Depth     = 32,
    parameter int unsigned Width     = CtrlBits + 2,
    parameter int unsigned AddrWidth = $clog2(Depth)
) (
    input  logic                 clk_i,
    input  logic                 wr_en_i,
    input  logic [AddrWidth-1:0] wr_addr_i,
    input  logic [Width-1:0]     wr_data_i,
    input  logic [AddrWidth-1:0] rd_addr_i,
    output logic [Width-1:0]     rd_data_o
);

    logic [Width-1:0] mem [Depth];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem[rd_addr_i];

endmodule

// File: rtl/hv_encoder_seq.sv
// Micro-program sequencer replaying host-loaded control words onto the HV encoder,
// with item-memory wait and query-HV back-pressure stalls.
module hv_encoder_seq
    import hv_enc_ctrl_pkg::*;
#(
    parameter  int unsigned InstDepth = 32,
    parameter  int unsigned IterWidth = 16,
    parameter  int unsigned CtrlWidth = CtrlBits,
    localparam int unsigned InstWidth = CtrlWidth + 2,
    localparam int unsigned AddrWidth = $clog2(InstDepth)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 inst_wr_en_i,
    input  logic [AddrWidth-1:0] inst_wr_addr_i,
    input  logic [InstWidth-1:0] inst_wr_data_i,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic [AddrWidth:0]   prog_len_i,
    input  logic [IterWidth-1:0] num_iter_i,
    input  logic                 im_valid_i,
    output logic                 im_ready_o,
    input  logic                 qhv_valid_i,
    output logic [CtrlWidth-1:0] ctrl_o,
    output logic                 busy_o,
    output logic                 done_o
);

    seq_state_e           state_q;
    logic [AddrWidth-1:0] pc_q;
    logic [IterWidth-1:0] iter_q;
    logic [AddrWidth:0]   prog_len_q;
    logic [IterWidth-1:0] num_iter_q;
    logic                 done_q;

    logic [InstWidth-1:0] inst;
    logic [CtrlWidth-1:0] word;
    logic                 run;
    logic                 im_req;
    logic                 stall;
    logic                 last_pc;
    logic                 last_iter;
    logic                 unused_last;

    hv_inst_mem #(
        .Depth     (InstDepth),
        .Width     (InstWidth),
        .AddrWidth (AddrWidth)
    ) u_inst_mem (
        .clk_i     (clk_i),
        .wr_en_i   (inst_wr_en_i && state_q == IDLE),
        .wr_addr_i (inst_wr_addr_i),
        .wr_data_i (inst_wr_data_i),
        .rd_addr_i (pc_q),
        .rd_data_o (inst)
    );

    assign run         = (state_q == RUN);
    assign word        = inst[CtrlWidth-1:0];
    assign im_req      = inst[CtrlWidth];
    assign unused_last = inst[InstWidth-1];
    assign stall       = (im_req && !im_valid_i) || (word[QhvWenLsb] && qhv_valid_i);
    assign last_pc     = ({1'b0, pc_q} == prog_len_q - 1'b1);
    assign last_iter   = (iter_q == num_iter_q - 1'b1);

    always_comb begin
        ctrl_o = '0;
        if (run) begin
            ctrl_o = stall ? (word & ~CtrlWidth'(EnableMask)) : word;
        end
    end

    assign im_ready_o = run && im_req && !stall;
    assign busy_o     = run;
    assign done_o     = done_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            iter_q     <= '0;
            prog_len_q <= '0;
            num_iter_q <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort_i) begin
                state_q <= IDLE;
                pc_q    <= '0;
                iter_q  <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start_i) begin
                            if (prog_len_i != '0 && num_iter_i != '0) begin
                                state_q    <= RUN;
                                pc_q       <= '0;
                                iter_q     <= '0;
                                prog_len_q <= prog_len_i;
                                num_iter_q <= num_iter_i;
                            end else begin
                                done_q <= 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        if (!stall) begin
                            if (last_pc) begin
                                pc_q <= '0;
                                if (last_iter) begin
                                    state_q <= IDLE;
                                    iter_q  <= '0;
                                    done_q  <= 1'b1;
                                end else begin
                                    iter_q <= iter_q + 1'b1;
                                end
                            end else begin
                                pc_q <= pc_q + 1'b1;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule
